// File: rtl/qmult_seq.sv
// qmult_seq: sequential sign-magnitude Qm.n fixed-point multiplier.
// Shift-and-add over the N-1 magnitude bits of the multiplier, one bit per clock.
// Shares its number format and start/complete handshake with the fixed-point divider.
//
// Parameters:
//   Q - number of fractional bits
//   N - total word width including the sign bit (N-1 > Q)
//
// Ports:
//   clk            - system clock, rising edge
//   rst            - asynchronous active-high reset
//   i_start        - start request, sampled only while idle
//   i_multiplicand - sign-magnitude operand A
//   i_multiplier   - sign-magnitude operand B
//   o_result       - sign-magnitude product, held until the next completion
//   o_complete     - one-cycle pulse when o_result/o_overflow are updated
//   o_overflow     - product magnitude did not fit in N-1 bits (result saturated)
//   o_busy         - high while a multiplication is in flight
//
// Build option:
//   QMULT_ROUND_EN - when defined, the magnitude is rounded half up instead of truncated.
module qmult_seq #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         o_complete,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int W  = N - 1;      // magnitude width
  localparam int PW = 2 * W;      // full product width
  localparam int CW = $clog2(N);  // counter holds values up to N-1

  typedef enum logic {StIdle, StCalc} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_a;
  logic [W-1:0]    r_b;
  logic            r_sign;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_count;
  logic [N-1:0]    r_result;
  logic            r_complete;
  logic            r_overflow;
  logic            r_busy;

  logic [PW-1:0]   w_sum;
  logic [W-1:0]    w_mag;
  logic            w_ovf;
  logic [N-1:0]    w_result;
`ifdef QMULT_ROUND_EN
  logic [W:0]      w_mag_rnd;
`endif

  // Accumulator value after this iteration; on the last iteration it is the full product.
  assign w_sum = r_acc + (r_b[0] ? r_a : '0);

  always_comb begin
    w_ovf = |w_sum[PW-1:Q+W];
`ifdef QMULT_ROUND_EN
    // Round half up; a carry out of the magnitude field is treated as overflow.
    w_mag_rnd = {1'b0, w_sum[Q+W-1:Q]} + {{W{1'b0}}, w_sum[Q-1]};
    w_ovf     = w_ovf | w_mag_rnd[W];
    w_mag     = w_mag_rnd[W-1:0];
`else
    w_mag = w_sum[Q+W-1:Q];
`endif
    if (w_ovf) begin
      w_result = {r_sign, {W{1'b1}}};
    end else if (w_mag == '0) begin
      w_result = '0;  // never produce negative zero
    end else begin
      w_result = {r_sign, w_mag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_a        <= '0;
      r_b        <= '0;
      r_sign     <= 1'b0;
      r_acc      <= '0;
      r_count    <= '0;
      r_result   <= '0;
      r_complete <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_a     <= {{W{1'b0}}, i_multiplicand[W-1:0]};
            r_b     <= i_multiplier[W-1:0];
            r_sign  <= i_multiplicand[N-1] ^ i_multiplier[N-1];
            r_acc   <= '0;
            r_count <= CW'(W);
            r_busy  <= 1'b1;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          r_acc   <= w_sum;
          r_a     <= r_a << 1;
          r_b     <= r_b >> 1;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_result   <= w_result;
            r_overflow <= w_ovf;
            r_complete <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_result   = r_result;
  assign o_complete = r_complete;
  assign o_overflow = r_overflow;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_qmult_seq.sv
// Self-checking bench for qmult_seq (Q=16, N=32). Expected products come from a
// plain-arithmetic model of sign-magnitude fixed-point multiplication.
module tb_qmult_seq;

  localparam int Q   = 16;
  localparam int N   = 32;
  localparam int LAT = N - 1;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [31:0] i_multiplicand;
  logic [31:0] i_multiplier;
  logic [31:0] o_result;
  logic        o_complete;
  logic        o_overflow;
  logic        o_busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] prev_res;  // model's idea of the currently held o_result

  qmult_seq #(
    .Q(Q),
    .N(N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_multiplicand(i_multiplicand),
    .i_multiplier  (i_multiplier),
    .o_result      (o_result),
    .o_complete    (o_complete),
    .o_overflow    (o_overflow),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overflow, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, p, m;
    logic [30:0] mag;
    logic        ovf, s;
    ma = a[30:0];
    mb = b[30:0];
    p  = ma * mb;
    m  = p >> Q;
`ifdef QMULT_ROUND_EN
    m = m + ((p >> (Q - 1)) & 64'd1);
`endif
    ovf = (m > 64'h7FFF_FFFF);
    mag = ovf ? 31'h7FFF_FFFF : m[30:0];
    s   = a[31] ^ b[31];
    if (mag == 31'd0) s = 1'b0;
    return {ovf, s, mag};
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    i_multiplicand = a;
    i_multiplier   = b;
    i_start        = 1'b1;
    @(negedge clk);
    i_start        = 1'b0;
    i_multiplicand = $urandom;  // operands may change freely after acceptance
    i_multiplier   = $urandom;
  endtask

  // Waits (bounded) for o_complete, watching o_busy and the held result meanwhile.
  task automatic wait_done(input logic [31:0] hold_exp, output int lat,
                           output bit busy_ok, output bit hold_ok);
    lat     = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (o_complete !== 1'b1 && lat < 100) begin
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (o_result !== hold_exp) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (o_busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_start = 1'b0;
    i_multiplicand = '0;
    i_multiplier = '0;
    #1;
    checks++;
    if ({o_result, o_complete, o_overflow, o_busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h cmp=%b ovf=%b busy=%b want all 0",
               o_result, o_complete, o_overflow, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    prev_res = '0;
  endtask

  task automatic test_basic();
    logic [31:0] ta[3] = '{32'h0004_8000, 32'h8004_8000, 32'h8004_8000};
    logic [31:0] tb[3] = '{32'h0003_8000, 32'h0003_8000, 32'h8003_8000};
    logic [31:0] te[3] = '{32'h000F_C000, 32'h800F_C000, 32'h000F_C000};
    int lat;
    bit bok, hok;
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i]);
      wait_done(prev_res, lat, bok, hok);
      checks++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (!bok || !hok) begin
        errors++;
        $display("FAIL basic_busy_hold[%0d]: busy_ok=%0b hold_ok=%0b want 1 1", i, bok, hok);
      end
      checks++;
      if (o_result !== te[i] || o_overflow !== 1'b0) begin
        errors++;
        $display("FAIL basic_result[%0d]: got %h ovf=%b want %h ovf=0",
                 i, o_result, o_overflow, te[i]);
      end
      prev_res = te[i];
      @(negedge clk);
      checks++;
      if (o_complete !== 1'b0) begin
        errors++;
        $display("FAIL basic_pulse_width[%0d]: complete=%b one cycle later, want 0",
                 i, o_complete);
      end
    end
  endtask

  task automatic test_overflow_back_to_back();
    int lat;
    bit bok, hok;
    start_op(32'h4000_0000, 32'h0002_0000);
    wait_done(prev_res, lat, bok, hok);
    checks++;
    if (o_result !== 32'h7FFF_FFFF || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_saturate: got %h ovf=%b want 7fffffff ovf=1", o_result, o_overflow);
    end
    prev_res = 32'h7FFF_FFFF;
    // Start the next operation in the completion cycle.
    start_op(32'h0004_8000, 32'h0003_8000);
    wait_done(prev_res, lat, bok, hok);
    checks++;
    if (lat != LAT || !bok || !hok) begin
      errors++;
      $display("FAIL b2b_timing: lat=%0d busy_ok=%0b hold_ok=%0b want %0d 1 1",
               lat, bok, hok, LAT);
    end
    checks++;
    if (o_result !== 32'h000F_C000 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got %h ovf=%b want 000fc000 ovf=0", o_result, o_overflow);
    end
    prev_res = 32'h000F_C000;
    @(negedge clk);
  endtask

  task automatic test_neg_zero();
    int lat;
    bit bok, hok;
    logic [31:0] exp;
`ifdef QMULT_ROUND_EN
    exp = 32'h8000_0001;
`else
    exp = 32'h0000_0000;
`endif
    start_op(32'h8000_0001, 32'h0000_8000);
    wait_done(prev_res, lat, bok, hok);
    checks++;
    if (o_result !== exp || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL neg_zero: got %h ovf=%b want %h ovf=0", o_result, o_overflow, exp);
    end
    prev_res = exp;
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat;
    bit bok, hok;
    bit early_ok;
    early_ok = 1'b1;
    start_op(32'h0004_8000, 32'h0003_8000);
    for (int i = 0; i < 9; i++) begin
      if (o_busy !== 1'b1 || o_complete !== 1'b0) early_ok = 1'b0;
      @(negedge clk);
    end
    i_multiplicand = 32'h1234_5678;
    i_multiplier   = 32'h8765_4321;
    i_start        = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(prev_res, lat, bok, hok);
    lat = lat + 10;
    checks++;
    if (lat != LAT || !bok || !hok || !early_ok) begin
      errors++;
      $display("FAIL ignore_start_timing: lat=%0d busy_ok=%0b hold_ok=%0b early_ok=%0b want %0d",
               lat, bok, hok, early_ok, LAT);
    end
    checks++;
    if (o_result !== 32'h000F_C000) begin
      errors++;
      $display("FAIL ignore_start_result: got %h want 000fc000", o_result);
    end
    prev_res = 32'h000F_C000;
    // The ignored request must not have queued a second operation.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_queued: busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    start_op(32'h0004_8000, 32'h0003_8000);
    for (int i = 0; i < 14; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({o_result, o_complete, o_overflow, o_busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got res=%h cmp=%b ovf=%b busy=%b want all 0",
               o_result, o_complete, o_overflow, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_complete !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'd0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_mid_no_complete: activity seen after reset, want none");
    end
    prev_res = '0;
  endtask

  task automatic test_zero_hold();
    int lat;
    bit bok, hok;
    start_op(32'h0004_8000, 32'h0003_8000);
    wait_done(prev_res, lat, bok, hok);
    prev_res = 32'h000F_C000;
    @(negedge clk);
    start_op(32'h0000_0000, 32'hFFFF_FFFF);
    wait_done(prev_res, lat, bok, hok);
    checks++;
    if (!hok || lat != LAT) begin
      errors++;
      $display("FAIL zero_hold: hold_ok=%0b lat=%0d want 1 %0d", hok, lat, LAT);
    end
    checks++;
    if (o_result !== 32'h0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: got %h ovf=%b want 00000000 ovf=0", o_result, o_overflow);
    end
    prev_res = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    bit bok, hok;
    logic [31:0] a, b;
    logic [32:0] exp;
    int sh;
    for (int i = 0; i < 30; i++) begin
      a  = $urandom;
      sh = $urandom_range(0, 30);
      a  = {a[31], a[30:0] >> sh};
      b  = $urandom;
      sh = $urandom_range(0, 30);
      b  = {b[31], b[30:0] >> sh};
      if (i == 0) a = {1'b1, 31'h7FFF_FFFF};
      exp = model(a, b);
      start_op(a, b);
      wait_done(prev_res, lat, bok, hok);
      checks++;
      if (lat != LAT || !bok || !hok || {o_overflow, o_result} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: a=%h b=%h got res=%h ovf=%b lat=%0d busy_ok=%0b hold_ok=%0b want res=%h ovf=%b lat=%0d",
                 i, a, b, o_result, o_overflow, lat, bok, hok, exp[31:0], exp[32], LAT);
      end
      prev_res = exp[31:0];
      // Alternate between back-to-back and spaced starts.
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_back_to_back();
    test_neg_zero();
    test_ignore_start();
    test_reset_mid();
    test_zero_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qmult_seq.md
Name: qmult_seq

Overview:
Sequential fixed-point multiplier that performs the inverse of the team's fixed-point divider (qdiv/fpdiv).
- Operand format: sign-magnitude Qm.n, where bit N-1 is the sign, bits N-2..Q are the integer part and bits Q-1..0 are the fraction.
- Algorithm: shift-and-add, one multiplier bit per clock, with a start/complete handshake matching the divider's.
- Used in the Codec2 encoder datapath wherever a quotient is scaled back, so divide and multiply share one number format and one handshake.

Parameters:
Q, 16, number of fractional bits
N, 32, total word width including the sign bit (N-1 > Q)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i_start  input  1  start request, sampled only in IDLE
i_multiplicand  input  N  sign-magnitude Q-format operand A
i_multiplier  input  N  sign-magnitude Q-format operand B
o_result  output  N  sign-magnitude Q-format product, held until the next completion
o_complete  output  1  one-cycle pulse when o_result/o_overflow are updated
o_overflow  output  1  product magnitude exceeded N-1 bits (saturated)
o_busy  output  1  high while in CALC

Behaviour:
- Reset (async, rst=1): state=IDLE; o_result=0, o_complete=0, o_overflow=0, o_busy=0; all internal registers 0. Reset mid-operation abandons the computation; no completion pulse follows.
- States: IDLE, CALC.
- IDLE, i_start=1 at edge k:
  - latch magnitude A (N-1 bits) into a 2(N-1)-bit shift register;
  - latch magnitude B (N-1 bits);
  - latch sign = A[N-1] XOR B[N-1];
  - clear the accumulator; set iteration counter to N-1;
  - go to CALC; o_busy=1 from edge k.
- IDLE, i_start=0: hold all outputs.
- CALC, each edge:
  - if B LSB is 1, accumulator += shifted A;
  - shift A left by 1; shift B right by 1; decrement counter.
- Final (N-1th) iteration edge, k+N-1:
  - state returns to IDLE; o_busy=0;
  - o_result, o_overflow update; o_complete=1 for exactly that one cycle.
  - Latency: start edge to completion edge is N-1 clocks (31 for the default).
- Result formation from the 2(N-1)-bit product P:
  - magnitude M = P[Q+N-2:Q] (truncation toward zero);
  - overflow = OR of P[2N-3:Q+N-1];
  - on overflow: o_result = {sign, all ones} (saturate), o_overflow=1;
  - otherwise o_result = {sign, M}, o_overflow=0.
- Negative zero: if the final magnitude is 0, the sign bit is forced to 0.
- i_start while busy (CALC): ignored; the in-flight operands are unaffected.
- i_start during the o_complete cycle: the state is IDLE, so it is accepted; back-to-back operations are allowed.
- Operand inputs are sampled only at the accepting edge and may change freely afterwards.
- o_overflow is updated only at completion and holds its value until the next completion.

Optional Feature:
Macro QMULT_ROUND_EN.
- Defined: round half up on the magnitude; M = P[Q+N-2:Q] + P[Q-1]. If the rounding add carries out of N-1 bits, it counts as overflow and the result saturates. The negative-zero rule is applied after rounding. Latency is unchanged: rounding is combinational on the final edge.
- Undefined: truncation only; P[Q-1:0] is discarded.

Test Plan:
1. Reset, then A=0x00048000 (4.5), B=0x00038000 (3.5), start pulse -> o_busy high for 31 cycles; o_complete pulses once at 31 cycles; o_result=0x000FC000 (15.75); o_overflow=0.
2. A=0x80048000 (-4.5), B=0x00038000 -> o_result=0x800FC000. Repeat with both operands negative -> o_result=0x000FC000.
3. A=0x40000000 (16384.0), B=0x00020000 (2.0) -> o_overflow=1, o_result=0x7FFFFFFF. Follow with case 1 started in the complete cycle -> overflow clears and o_result=0x000FC000 31 cycles later.
4. A=0x80000001 (-2^-16), B=0x00008000 (0.5) -> without QMULT_ROUND_EN: o_result=0x00000000 (sign forced 0). With QMULT_ROUND_EN: o_result=0x80000001.
5. Start case 1; pulse i_start with different operands at cycle 10 -> ignored, result 0x000FC000 at 31 cycles. Start again, assert rst at cycle 15 -> all outputs 0 immediately, no o_complete afterwards.
6. A=0x00000000, B=0xFFFFFFFF -> o_result=0x00000000, o_overflow=0; previous o_result held in the cycles before completion.
